// File: rtl/rgb_to_phase_if.sv
// RGB-in / phase-out handshake bundle for the hue recovery block.
// master drives samples and result acceptance; slave is the converter.
interface rgb_to_phase_if #(
  parameter int CHAN_W  = 8,
  parameter int PHASE_W = 9
);
  logic               in_valid;
  logic               in_ready;
  logic [CHAN_W-1:0]  red;
  logic [CHAN_W-1:0]  green;
  logic [CHAN_W-1:0]  blue;
  logic               out_valid;
  logic               out_ready;
  logic [PHASE_W-1:0] phase;
  logic               grey;

  modport master (
    output in_valid, red, green, blue, out_ready,
    input  in_ready, out_valid, phase, grey
  );

  modport slave (
    input  in_valid, red, green, blue, out_ready,
    output in_ready, out_valid, phase, grey
  );
endinterface

// File: rtl/rgb_to_phase.sv
// Recovers hue (0..359 deg) from an RGB pixel on a three-sector wheel via a 7-step restoring divider.
// Latency: result 8 edges after accept (1 edge for grey); one sample in flight; result held until out_ready.
module rgb_to_phase #(
  parameter int CHAN_W  = 8,
  parameter int PHASE_W = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  rgb_to_phase_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, DIV, DONE} state_t;

  state_t              state, state_nx;
  logic [CHAN_W-1:0]   r_q, g_q, b_q;
  logic [9:0]          rem_q;
  logic [6:0]          dvd_q;
  logic [8:0]          den_q;
  logic [5:0]          quo_q;
  logic [8:0]          base_q;
  logic [2:0]          cnt_q;
  logic [PHASE_W-1:0]  phase_q;
  logic                grey_q;

  logic [8:0]          s_base;
  logic [CHAN_W-1:0]   s_num;
  logic [8:0]          s_den;
  logic [15:0]         s_dvd;

  logic [9:0]          trial;
  logic                fits;
  logic [9:0]          rem_nx;
  logic [6:0]          q_full;
  logic [8:0]          sum;
  logic [8:0]          sum_wrap;

  // Minimum channel picks the sector; ties resolve blue, then red, then green.
  always_comb begin
    s_base = '0;
    s_num  = '0;
    s_den  = '0;
    if (b_q <= r_q && b_q <= g_q) begin
      s_base = 9'd0;
      s_num  = g_q - b_q;
      s_den  = {1'b0, r_q - b_q} + {1'b0, g_q - b_q};
    end else if (r_q <= g_q) begin
      s_base = 9'd120;
      s_num  = b_q - r_q;
      s_den  = {1'b0, g_q - r_q} + {1'b0, b_q - r_q};
    end else begin
      s_base = 9'd240;
      s_num  = r_q - g_q;
      s_den  = {1'b0, b_q - g_q} + {1'b0, r_q - g_q};
    end
    s_dvd = 16'(s_num) * 16'd120;
  end

  // Quotient never exceeds 127, so dividend[15:7] < den and seeds the remainder directly.
  always_comb begin
    trial    = (rem_q << 1) | {9'd0, dvd_q[6]};
    fits     = (trial >= {1'b0, den_q});
    rem_nx   = fits ? (trial - {1'b0, den_q}) : trial;
    q_full   = {quo_q, fits};
    sum      = base_q + {2'b00, q_full};
    sum_wrap = (sum == 9'd360) ? 9'd0 : sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (bus.in_valid)    state_nx = SETUP;
      SETUP: state_nx = (s_den == 9'd0) ? DONE : DIV;
      DIV:   if (cnt_q == 3'd0)   state_nx = DONE;
      DONE:  if (bus.out_ready)   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      den_q   <= '0;
      quo_q   <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
      phase_q <= '0;
      grey_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            r_q <= bus.red;
            g_q <= bus.green;
            b_q <= bus.blue;
          end
        end
        SETUP: begin
          rem_q  <= {1'b0, s_dvd[15:7]};
          dvd_q  <= s_dvd[6:0];
          den_q  <= s_den;
          base_q <= s_base;
          quo_q  <= '0;
          cnt_q  <= 3'd6;
          if (s_den == 9'd0) begin
            grey_q  <= 1'b1;
            phase_q <= '0;
          end
        end
        DIV: begin
          rem_q <= rem_nx;
          dvd_q <= {dvd_q[5:0], 1'b0};
          quo_q <= q_full[5:0];
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd0) begin
            phase_q <= PHASE_W'(sum_wrap);
            grey_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.phase     = phase_q;
  assign bus.grey      = grey_q;

endmodule

// File: tb/tb_rgb_to_phase.sv
// Directed bench for rgb_to_phase: driver pushes expected results, negedge monitor pops and compares.
module tb_rgb_to_phase;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rgb_to_phase_if #(.CHAN_W(8), .PHASE_W(9)) bus ();

  rgb_to_phase #(.CHAN_W(8), .PHASE_W(9)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_phase_q[$];
  int exp_grey_q[$];
  string exp_name_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: one pop per completed output handshake.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_phase_q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        string nm;
        int ep, eg;
        nm = exp_name_q.pop_front();
        ep = exp_phase_q.pop_front();
        eg = exp_grey_q.pop_front();
        chk({nm, "_phase"}, int'(bus.phase), ep);
        chk({nm, "_grey"}, int'(bus.grey), eg);
      end
    end
  end

  task automatic expect_result(input string name, input int ph, input int gr);
    exp_name_q.push_back(name);
    exp_phase_q.push_back(ph);
    exp_grey_q.push_back(gr);
  endtask

  // Called #1 after a posedge; returns #1 after the accept edge with channels scrambled.
  task automatic accept(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int n;
    bus.red = r;
    bus.green = g;
    bus.blue = b;
    bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("accept_timeout", 1, 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.red   = 8'($urandom_range(0, 255));
    bus.green = 8'($urandom_range(0, 255));
    bus.blue  = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!bus.out_valid && lat < 50);
  endtask

  task automatic run(input string name, input logic [7:0] r, input logic [7:0] g,
                     input logic [7:0] b, input int ph, input int gr);
    int lat;
    expect_result(name, ph, gr);
    accept(r, g, b);
    wait_valid(lat);
    chk({name, "_latency"}, lat, (gr != 0) ? 1 : 8);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    bus.in_valid = 1'b0;
    bus.red = '0;
    bus.green = '0;
    bus.blue = '0;
    bus.out_ready = 1'b1;

    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_phase", int'(bus.phase), 0);
    chk("rst_grey", int'(bus.grey), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run("red",      8'd255, 8'd0,   8'd0,   0,   0);
    run("green",    8'd0,   8'd255, 8'd0,   120, 0);
    run("blue",     8'd0,   8'd0,   8'd255, 240, 0);
    run("magenta",  8'd255, 8'd0,   8'd255, 300, 0);
    run("near_mag", 8'd126, 8'd0,   8'd129, 299, 0);
    run("olive",    8'd128, 8'd128, 8'd0,   60,  0);
    run("grey77",   8'd77,  8'd77,  8'd77,  0,   1);
    run("orange",   8'd255, 8'd128, 8'd0,   40,  0);
    run("black",    8'd0,   8'd0,   8'd0,   0,   1);
    run("azure",    8'd0,   8'd128, 8'd255, 199, 0);

    // Backpressure: result held 20 cycles while a new sample waits.
    bus.out_ready = 1'b0;
    expect_result("bp_first", 300, 0);
    accept(8'd255, 8'd0, 8'd255);
    wait_valid(lat);
    chk("bp_first_latency", lat, 8);
    expect_result("bp_second", 200, 0);
    bus.red = 8'd10;
    bus.green = 8'd20;
    bus.blue = 8'd30;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_hold_phase", int'(bus.phase), 300);
      chk("bp_hold_in_ready", int'(bus.in_ready), 0);
      chk("bp_hold_out_valid", int'(bus.out_valid), 1);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_in_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    chk("bp_after_out_valid", int'(bus.out_valid), 0);
    chk("bp_after_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_valid(lat);
    chk("bp_second_latency", lat, 8);
    @(posedge clk);
    #1;

    // Reset during the 4th divide cycle aborts the sample.
    chk("pre_rst_phase", int'(bus.phase), 200);
    accept(8'd255, 8'd128, 8'd0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    chk("mid_rst_phase", int'(bus.phase), 0);
    chk("mid_rst_in_ready", int'(bus.in_ready), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post_rst_no_output", int'(bus.out_valid), 0);
    end
    @(posedge clk);
    #1;
    run("post_rst_green", 8'd0, 8'd255, 8'd0, 120, 0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", exp_phase_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
